// File: rtl/mu0_host_loader_if.sv
// Host-loader signal bundle: UART byte streams, mu0 memory-override port and run control.
interface mu0_host_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_ctrl;
  logic        mem_rnw;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        cpu_enable;
  logic        cpu_start;
  logic        cpu_done;
  logic [15:0] cpu_acc;
  logic        busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, mem_rdata, cpu_done, cpu_acc,
    output rx_ready, tx_data, tx_valid, mem_ctrl, mem_rnw, mem_addr, mem_wdata,
           cpu_enable, cpu_start, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, mem_rdata, cpu_done, cpu_acc,
    input  rx_ready, tx_data, tx_valid, mem_ctrl, mem_rnw, mem_addr, mem_wdata,
           cpu_enable, cpu_start, busy
  );
endinterface

// File: rtl/mu0_host_loader.sv
// Host byte-stream front end for the mu0 core: loads and reads memory through the
// override port, starts runs and returns the accumulator to the host.
module mu0_host_loader #(
  parameter int unsigned READ_LAT    = 2,
  parameter int unsigned RUN_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  mu0_host_loader_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, HDR, WHI, WLO, WRITE, RADDR, RWAIT, THI, TLO,
    RUNEN, RUNGO, RUNWAIT, TACC_HI, TACC_LO, RESP
  } state_e;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_READ = 8'h52;
  localparam logic [7:0] CMD_GO   = 8'h47;
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;
  localparam logic [7:0] DONE_TAG = 8'h44;

  state_e      state_q;
  logic        rx_ready_q, busy_q, tx_valid_q;
  logic        mem_ctrl_q, mem_rnw_q, cpu_enable_q, cpu_start_q;
  logic        is_load_q, acc_tag_q;
  logic [7:0]  tx_data_q, whi_q, lo_q;
  logic [1:0]  hdr_idx_q;
  logic [15:0] addr_q, cnt_q, mem_wdata_q, acc_q;
  logic [31:0] lat_q, run_q;
  logic [15:0] addr_d, cnt_d;
  logic        rx_fire, tx_fire, hdr_cnt_zero;

  assign addr_d       = addr_q + 16'd1;
  assign cnt_d        = cnt_q - 16'd1;
  assign rx_fire      = bus.rx_valid & rx_ready_q;
  assign tx_fire      = tx_valid_q & bus.tx_ready;
  assign hdr_cnt_zero = (cnt_q[15:8] == 8'h00) && (bus.rx_data == 8'h00);

  assign bus.rx_ready   = rx_ready_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.mem_ctrl   = mem_ctrl_q;
  assign bus.mem_rnw    = mem_rnw_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.cpu_enable = cpu_enable_q;
  assign bus.cpu_start  = cpu_start_q;
  assign bus.busy       = busy_q;

  // rx_ready and busy are registered alongside the state so they track it exactly
  task automatic go(input state_e s);
    state_q    <= s;
    rx_ready_q <= (s == IDLE) || (s == HDR) || (s == WHI) || (s == WLO);
    busy_q     <= (s != IDLE);
  endtask

  task automatic respond(input logic [7:0] b);
    tx_data_q  <= b;
    tx_valid_q <= 1'b1;
    go(RESP);
  endtask

  task automatic start_read();
    mem_ctrl_q <= 1'b1;
    mem_rnw_q  <= 1'b1;
    go(RADDR);
  endtask

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rx_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      mem_ctrl_q   <= 1'b0;
      mem_rnw_q    <= 1'b1;
      mem_wdata_q  <= 16'h0000;
      cpu_enable_q <= 1'b0;
      cpu_start_q  <= 1'b0;
      is_load_q    <= 1'b0;
      acc_tag_q    <= 1'b0;
      whi_q        <= 8'h00;
      lo_q         <= 8'h00;
      hdr_idx_q    <= 2'd0;
      addr_q       <= 16'h0000;
      cnt_q        <= 16'h0000;
      acc_q        <= 16'h0000;
      lat_q        <= '0;
      run_q        <= '0;
    end else begin
      cpu_enable_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rx_fire) begin
            hdr_idx_q <= 2'd0;
            is_load_q <= (bus.rx_data == CMD_LOAD);
            if (bus.rx_data == CMD_LOAD || bus.rx_data == CMD_READ) begin
              go(HDR);
            end else if (bus.rx_data == CMD_GO) begin
              cpu_enable_q <= 1'b1;
              go(RUNEN);
            end else begin
              respond(NAK);
            end
          end else begin
            go(IDLE);
          end
        end
        HDR: if (rx_fire) begin
          hdr_idx_q <= hdr_idx_q + 2'd1;
          unique case (hdr_idx_q)
            2'd0: addr_q[15:8] <= bus.rx_data;
            2'd1: addr_q[7:0]  <= bus.rx_data;
            2'd2: cnt_q[15:8]  <= bus.rx_data;
            default: begin
              cnt_q[7:0] <= bus.rx_data;
              if (hdr_cnt_zero) begin
                if (is_load_q) respond(ACK);
                else           go(IDLE);
              end else if (is_load_q) begin
                go(WHI);
              end else begin
                start_read();
              end
            end
          endcase
        end
        WHI: if (rx_fire) begin
          whi_q <= bus.rx_data;
          go(WLO);
        end
        WLO: if (rx_fire) begin
          mem_wdata_q <= {whi_q, bus.rx_data};
          mem_ctrl_q  <= 1'b1;
          mem_rnw_q   <= 1'b0;
          go(WRITE);
        end
        WRITE: begin
          mem_ctrl_q <= 1'b0;
          mem_rnw_q  <= 1'b1;
          addr_q     <= addr_d;
          cnt_q      <= cnt_d;
          if (cnt_d == 16'h0000) respond(ACK);
          else                   go(WHI);
        end
        RADDR: begin
          lat_q <= '0;
          go(RWAIT);
        end
        // The last RWAIT cycle is READ_LAT cycles after the address was first presented
        RWAIT: begin
          if (lat_q == READ_LAT - 1) begin
            lo_q       <= bus.mem_rdata[7:0];
            tx_data_q  <= bus.mem_rdata[15:8];
            tx_valid_q <= 1'b1;
            mem_ctrl_q <= 1'b0;
            go(THI);
          end else begin
            lat_q <= lat_q + 1;
          end
        end
        THI: if (tx_fire) begin
          tx_data_q <= lo_q;
          go(TLO);
        end
        TLO: if (tx_fire) begin
          tx_valid_q <= 1'b0;
          addr_q     <= addr_d;
          cnt_q      <= cnt_d;
          if (cnt_d == 16'h0000) go(IDLE);
          else                   start_read();
        end
        RUNEN: begin
          cpu_start_q <= ~cpu_start_q;
          go(RUNGO);
        end
        RUNGO: begin
          run_q <= '0;
          go(RUNWAIT);
        end
        // cpu_done may still be stale on the first wait cycle, so it is ignored there
        RUNWAIT: begin
          if (run_q != '0 && bus.cpu_done) begin
            acc_q      <= bus.cpu_acc;
            acc_tag_q  <= 1'b0;
            tx_data_q  <= DONE_TAG;
            tx_valid_q <= 1'b1;
            go(TACC_HI);
          end else if (run_q == RUN_TIMEOUT - 1) begin
            respond(NAK);
          end else begin
            run_q <= run_q + 1;
          end
        end
        TACC_HI: if (tx_fire) begin
          if (!acc_tag_q) begin
            tx_data_q <= acc_q[15:8];
            acc_tag_q <= 1'b1;
          end else begin
            tx_data_q <= acc_q[7:0];
            go(TACC_LO);
          end
        end
        TACC_LO, RESP: if (tx_fire) begin
          tx_valid_q <= 1'b0;
          go(IDLE);
        end
        default: go(IDLE);
      endcase
    end
  end

endmodule

// File: doc/mu0_host_loader.md
Name: mu0_host_loader

Overview:
- Host-side front end for the mu0 core. Sits directly upstream of it.
- Takes a byte stream from a UART receiver and drives the core's memory-override port to load and read back programs.
- Starts a run by toggling the core's start line, waits for done, then returns the accumulator to the host on a transmit byte stream.
- The only block allowed to assert memory override; it releases memory while the core runs.

Parameters:
- READ_LAT, 2, clk cycles from mem_addr/mem_rnw=1 being presented with mem_ctrl=1 until mem_rdata is valid.
- RUN_TIMEOUT, 65535, max clk cycles to wait for cpu_done after start toggle.

Ports:
- clk  in  1  system clock (core clk domain)
- reset  in  1  synchronous, active-high
- rx_data  in  8  host byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts rx_data this cycle
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts tx_data
- mem_ctrl  out  1  drives core overrideMemControl
- mem_rnw  out  1  drives overrideMemRnW
- mem_addr  out  16  drives overrideMemAddr
- mem_wdata  out  16  drives overrideMemDataIn
- mem_rdata  in  16  from overrideMemDataOut
- cpu_enable  out  1  one-cycle pulse that clears core done
- cpu_start  out  1  level; each toggle restarts the core
- cpu_done  in  1  core done flag
- cpu_acc  in  16  core accumulator
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, synchronous and dominant over everything:
  - rx_ready=0, tx_valid=0, tx_data=0, mem_ctrl=0, mem_rnw=1, mem_addr=0, mem_wdata=0, cpu_enable=0, cpu_start=0, busy=0.
  - All counters cleared; state = IDLE.
  - Reset during any command aborts it: no ACK, no partial-byte memory write.
- Byte transfer rules:
  - An rx byte is consumed on a cycle with rx_valid & rx_ready.
  - A tx byte completes on a cycle with tx_valid & tx_ready.
  - tx_data is held stable while tx_valid=1 and tx_ready=0.
- All multi-byte fields are big-endian (high byte first).
- States: IDLE, HDR (collect 4 bytes: addr_hi, addr_lo, cnt_hi, cnt_lo), WHI, WLO, WRITE, RADDR, RWAIT, THI, TLO, RUNEN, RUNGO, RUNWAIT, TACC_HI, TACC_LO, RESP.
- rx_ready=1 only in IDLE, HDR, WHI and WLO.
- Command bytes accepted in IDLE:
  - 0x4C 'L' (load): HDR, then cnt words. Each word goes WHI, WLO, then WRITE. WRITE drives mem_ctrl=1, mem_rnw=0, mem_addr=addr, mem_wdata={hi,lo} for exactly 1 cycle; then addr+=1, cnt-=1. When cnt reaches 0, go to RESP with 0x06.
  - 0x52 'R' (read): HDR, then per word:
    - RADDR drives mem_ctrl=1, mem_rnw=1, mem_addr=addr.
    - RWAIT holds those signals for READ_LAT cycles, then latches mem_rdata.
    - mem_ctrl drops to 0; THI sends the high byte, TLO sends the low byte.
    - addr+=1, cnt-=1. When cnt reaches 0, return to IDLE; no ACK is sent after a read.
  - 0x47 'G' (go):
    - RUNEN: cpu_enable=1 for 1 cycle.
    - RUNGO: cpu_start toggles (inverts) for 1 cycle.
    - RUNWAIT counts cycles while mem_ctrl=0.
    - cpu_done=1 (sampled from the second RUNWAIT cycle onward) → TACC_HI sends 0x44 'D', acc_hi; TACC_LO sends acc_lo. acc is cpu_acc latched when done is seen. Then IDLE.
    - Timeout (RUN_TIMEOUT cycles without done) → RESP with 0x15.
  - Any other byte → RESP with 0x15 NAK.
- cnt=0 in the header: 'L' sends ACK immediately with no memory access; 'R' returns to IDLE with no bytes sent.
- Address arithmetic is 16-bit and wraps: 0xFFFF+1 = 0x0000.
- mem_ctrl=1 only in WRITE, RADDR and RWAIT; it is never 1 in RUN* states.
- No command queuing: bytes arriving while busy stall (rx_ready=0).

Test Plan:
- Reset mid-'L' after addr_hi, then send 'R' 0x00 0x00 0x00 0x01 → the word reads unchanged from its pre-load value; no stray ACK; all outputs at reset values for the cycle after reset.
- 'L' 00 10 00 02 12 34 AB CD → two 1-cycle writes: (0x0010, 0x1234), (0x0011, 0xABCD); tx 0x06. Then 'R' 00 10 00 02 → tx 12 34 AB CD.
- 'L' FF FF 00 02 …, wrap case → writes land at 0xFFFF then 0x0000.
- Load program LDA 5 / STP with mem[5]=0x0007, then 'G' → one cpu_enable pulse, cpu_start toggles once, mem_ctrl=0 throughout the run; tx 44 00 07.
- 'G' with cpu_done tied 0 and RUN_TIMEOUT=16 → tx 0x15 after 16 cycles.
- Byte 0x99 in IDLE → tx 0x15. tx_ready held low 5 cycles during any response → tx_data stable; no byte lost or duplicated.
